// File: rtl/bird_collision_monitor.sv
// Collision detection, game state machine and scoring for the bird game, one step per frame.
// Optional build macro BIRD_HIGH_SCORE_EN adds a high_score output kept across games.
module bird_collision_monitor #(
  parameter logic [9:0] PIPE_HALF_W = 10'd20,
  parameter logic [9:0] GAP_HALF    = 10'd50,
  parameter logic [9:0] FLOOR_Y     = 10'd479,
  parameter logic [5:0] HIT_FRAMES  = 6'd30,
  parameter logic [7:0] START_KEY   = 8'h1A
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] BirdX,
  input  logic [9:0] BirdY,
  input  logic [9:0] BirdS,
  input  logic [9:0] Pipe1X,
  input  logic [9:0] Pipe1Y,
  input  logic [9:0] Pipe2X,
  input  logic [9:0] Pipe2Y,
  output logic       game_active,
  output logic       freeze,
  output logic       game_over,
  output logic       hit_pulse,
`ifdef BIRD_HIGH_SCORE_EN
  output logic [7:0] high_score,
`endif
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  score_r, score_nxt_s;
  logic [5:0]  cnt_r, cnt_nxt_s;
  logic        armed1_r, armed1_nxt_s, armed2_r, armed2_nxt_s;
  logic        key_rel_r, key_rel_nxt_s;
  logic        hit_s;
  logic        game_active_r, freeze_r, game_over_r, hit_pulse_r;
  logic        collide_s, pass1_s, pass2_s, back1_s, back2_s;
  logic [1:0]  inc_s;
`ifdef BIRD_HIGH_SCORE_EN
  logic [7:0]  hs_r, hs_nxt_s;
`endif

  function automatic logic [10:0] ext(input logic [9:0] v);
    return {1'b0, v};
  endfunction

  // Negative results clamp to zero instead of wrapping.
  function automatic logic [10:0] sub_clamp(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : 11'd0;
  endfunction

  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic pipe_hit(input logic [9:0] px, input logic [9:0] py);
    logic overlap;
    logic outside;
    overlap = abs_diff(ext(BirdX), ext(px)) <= (ext(BirdS) + ext(PIPE_HALF_W));
    outside = (sub_clamp(ext(BirdY), ext(BirdS)) < sub_clamp(ext(py), ext(GAP_HALF))) ||
              ((ext(BirdY) + ext(BirdS)) > (ext(py) + ext(GAP_HALF)));
    return overlap && outside;
  endfunction

  function automatic logic pipe_passed(input logic [9:0] px);
    return (ext(px) + ext(PIPE_HALF_W)) < sub_clamp(ext(BirdX), ext(BirdS));
  endfunction

  function automatic logic pipe_back(input logic [9:0] px);
    return ext(px) > (ext(BirdX) + ext(BirdS));
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign collide_s = pipe_hit(Pipe1X, Pipe1Y) || pipe_hit(Pipe2X, Pipe2Y) ||
                     ((ext(BirdY) + ext(BirdS)) >= ext(FLOOR_Y));
  assign pass1_s   = armed1_r && pipe_passed(Pipe1X);
  assign pass2_s   = armed2_r && pipe_passed(Pipe2X);
  assign back1_s   = pipe_back(Pipe1X);
  assign back2_s   = pipe_back(Pipe2X);
  assign inc_s     = {1'b0, pass1_s} + {1'b0, pass2_s};

  // Next-state, score, arming and hit-counter logic.
  always_comb begin
    state_nxt_s   = state_r;
    score_nxt_s   = score_r;
    cnt_nxt_s     = cnt_r;
    armed1_nxt_s  = armed1_r;
    armed2_nxt_s  = armed2_r;
    key_rel_nxt_s = key_rel_r;
    hit_s         = 1'b0;
`ifdef BIRD_HIGH_SCORE_EN
    hs_nxt_s      = hs_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (keycode == START_KEY) begin
          state_nxt_s  = ST_PLAY;
          score_nxt_s  = 8'd0;
          armed1_nxt_s = 1'b1;
          armed2_nxt_s = 1'b1;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // A crash wins over a pass seen in the same frame.
        if (collide_s) begin
          state_nxt_s  = ST_HIT;
          hit_s        = 1'b1;
          cnt_nxt_s    = HIT_FRAMES - 6'd1;
        end else begin
          score_nxt_s  = sat_add(score_r, inc_s);
          armed1_nxt_s = pass1_s ? 1'b0 : (back1_s ? 1'b1 : armed1_r);
          armed2_nxt_s = pass2_s ? 1'b0 : (back2_s ? 1'b1 : armed2_r);
        end
      end
      ST_HIT: begin
        if (cnt_r == 6'd0) begin
          state_nxt_s   = ST_OVER;
          key_rel_nxt_s = 1'b0;
`ifdef BIRD_HIGH_SCORE_EN
          hs_nxt_s      = (score_r > hs_r) ? score_r : hs_r;
`endif
        end else begin
          cnt_nxt_s     = cnt_r - 6'd1;
        end
      end
      ST_OVER: begin
        // The start key must be released once before it can restart the game.
        if (key_rel_r && (keycode == START_KEY)) begin
          state_nxt_s   = ST_IDLE;
        end else if (keycode == 8'h00) begin
          key_rel_nxt_s = 1'b1;
        end else begin
          key_rel_nxt_s = key_rel_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      score_r       <= 8'd0;
      cnt_r         <= 6'd0;
      armed1_r      <= 1'b1;
      armed2_r      <= 1'b1;
      key_rel_r     <= 1'b0;
      game_active_r <= 1'b0;
      freeze_r      <= 1'b1;
      game_over_r   <= 1'b0;
      hit_pulse_r   <= 1'b0;
`ifdef BIRD_HIGH_SCORE_EN
      hs_r          <= 8'd0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      score_r       <= score_nxt_s;
      cnt_r         <= cnt_nxt_s;
      armed1_r      <= armed1_nxt_s;
      armed2_r      <= armed2_nxt_s;
      key_rel_r     <= key_rel_nxt_s;
      game_active_r <= (state_nxt_s == ST_PLAY);
      freeze_r      <= (state_nxt_s != ST_PLAY);
      game_over_r   <= (state_nxt_s == ST_OVER);
      hit_pulse_r   <= hit_s;
`ifdef BIRD_HIGH_SCORE_EN
      hs_r          <= hs_nxt_s;
`endif
    end
  end

  assign game_active = game_active_r;
  assign freeze      = freeze_r;
  assign game_over   = game_over_r;
  assign hit_pulse   = hit_pulse_r;
  assign score       = score_r;
`ifdef BIRD_HIGH_SCORE_EN
  assign high_score  = hs_r;
`endif

endmodule

// File: tb/tb_bird_collision_monitor.sv
// Directed self-checking bench for bird_collision_monitor; covers BIRD_HIGH_SCORE_EN when defined.
module tb_bird_collision_monitor;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] BirdX, BirdY, BirdS, Pipe1X, Pipe1Y, Pipe2X, Pipe2Y;
  logic       game_active, freeze, game_over, hit_pulse;
  logic [7:0] score;
`ifdef BIRD_HIGH_SCORE_EN
  logic [7:0] high_score;
`endif
  int total = 0;
  int bad   = 0;

  always #5 frame_clk = ~frame_clk;

  bird_collision_monitor dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .BirdX(BirdX), .BirdY(BirdY), .BirdS(BirdS),
    .Pipe1X(Pipe1X), .Pipe1Y(Pipe1Y), .Pipe2X(Pipe2X), .Pipe2Y(Pipe2Y),
    .game_active(game_active), .freeze(freeze), .game_over(game_over),
    .hit_pulse(hit_pulse),
`ifdef BIRD_HIGH_SCORE_EN
    .high_score(high_score),
`endif
    .score(score)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode = 8'h00;
    BirdX = 10'd100; BirdY = 10'd200; BirdS = 10'd4;
    Pipe1X = 10'd300; Pipe1Y = 10'd200; Pipe2X = 10'd600; Pipe2Y = 10'd200;
    #2;
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL reset_freeze got=%0b want=1", freeze); end
    total++; if (game_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0b want=0", game_active); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%0b want=0", game_over); end
    total++; if (hit_pulse !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b want=0", hit_pulse); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", score); end
    tick(); tick();
    Reset = 1'b0;
    tick();
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL idle_nokey got=%0b want=1", freeze); end
  endtask

  task automatic test_start();
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    total++; if (game_active !== 1'b1) begin bad++; $display("FAIL start_active got=%0b want=1", game_active); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL start_freeze got=%0b want=0", freeze); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL start_score got=%0d want=0", score); end
  endtask

  task automatic test_scoring();
    Pipe1X = 10'd77; tick();  // 97 < 96 false, bird within the gap
    total++; if (score !== 8'd0 || game_active !== 1'b1) begin bad++; $display("FAIL score_near got=%0d/%0b want=0/1", score, game_active); end
    Pipe1X = 10'd70; tick();  // 90 < 96
    total++; if (score !== 8'd1) begin bad++; $display("FAIL score_first got=%0d want=1", score); end
    Pipe1X = 10'd60; tick();
    total++; if (score !== 8'd1) begin bad++; $display("FAIL score_disarmed got=%0d want=1", score); end
    Pipe1X = 10'd600; tick();
    total++; if (score !== 8'd1) begin bad++; $display("FAIL score_rearm got=%0d want=1", score); end
    Pipe1X = 10'd70; tick();
    total++; if (score !== 8'd2) begin bad++; $display("FAIL score_second got=%0d want=2", score); end
    Pipe1X = 10'd600; tick();
    Pipe1X = 10'd70; Pipe2X = 10'd70; tick();
    total++; if (score !== 8'd4) begin bad++; $display("FAIL score_both got=%0d want=4", score); end
    Pipe1X = 10'd600; Pipe2X = 10'd600; tick();
  endtask

  task automatic test_floor_hit();
    keycode = 8'h1A; BirdY = 10'd476; Pipe1X = 10'd70;  // floor hit and pass condition together
    tick();
    total++; if (hit_pulse !== 1'b1) begin bad++; $display("FAIL floor_pulse got=%0b want=1", hit_pulse); end
    total++; if (freeze !== 1'b1 || game_active !== 1'b0) begin bad++; $display("FAIL floor_freeze got=%0b/%0b want=1/0", freeze, game_active); end
    total++; if (score !== 8'd4) begin bad++; $display("FAIL floor_noscore got=%0d want=4", score); end
    tick();
    total++; if (hit_pulse !== 1'b0) begin bad++; $display("FAIL floor_pulse_end got=%0b want=0", hit_pulse); end
    for (int i = 0; i < 28; i++) begin
      tick();
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL hit_early_over frame=%0d got=%0b want=0", i + 2, game_over); end
    end
    tick();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL hit_to_over got=%0b want=1", game_over); end
  endtask

  task automatic test_restart();
    BirdY = 10'd200; Pipe1X = 10'd600;
    tick();  // start key still held from the crash
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_held_key got=%0b want=1", game_over); end
    keycode = 8'h00; tick();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_release got=%0b want=1", game_over); end
    keycode = 8'h1A; tick();
    total++; if (game_over !== 1'b0 || freeze !== 1'b1 || game_active !== 1'b0) begin bad++; $display("FAIL over_to_idle got=%0b%0b%0b want=010", game_over, freeze, game_active); end
    total++; if (score !== 8'd4) begin bad++; $display("FAIL idle_score_hold got=%0d want=4", score); end
    tick();
    keycode = 8'h00;
    total++; if (game_active !== 1'b1 || score !== 8'd0) begin bad++; $display("FAIL restart_play got=%0b/%0d want=1/0", game_active, score); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 130; i++) begin
      Pipe1X = 10'd600; Pipe2X = 10'd600; tick();
      Pipe1X = 10'd70;  Pipe2X = 10'd70;  tick();
      if (i == 0) begin
        total++; if (score !== 8'd2) begin bad++; $display("FAIL sat_first got=%0d want=2", score); end
      end
    end
    total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_limit got=%0d want=255", score); end
  endtask

  task automatic test_pipe_hit_and_reset();
    BirdY = 10'd100; Pipe1X = 10'd110; Pipe2X = 10'd600;  // 96 < 150: above the gap
    tick();
    total++; if (hit_pulse !== 1'b1 || freeze !== 1'b1) begin bad++; $display("FAIL pipe_hit got=%0b/%0b want=1/1", hit_pulse, freeze); end
    tick();
    total++; if (hit_pulse !== 1'b0 || score !== 8'd255) begin bad++; $display("FAIL pipe_hit_after got=%0b/%0d want=0/255", hit_pulse, score); end
    for (int i = 0; i < 16; i++) tick();
    #2 Reset = 1'b1;
    #1;
    total++; if (freeze !== 1'b1 || game_active !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL async_reset got=%0b%0b%0b want=100", freeze, game_active, game_over); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL async_reset_score got=%0d want=0", score); end
    tick();
    Reset = 1'b0; BirdY = 10'd200; Pipe1X = 10'd600;
    tick();
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL post_reset_idle got=%0b want=1", freeze); end
    keycode = 8'h1A; tick(); keycode = 8'h00;
    total++; if (game_active !== 1'b1) begin bad++; $display("FAIL post_reset_start got=%0b want=1", game_active); end
  endtask

`ifdef BIRD_HIGH_SCORE_EN
  task automatic play_and_crash(input int n);
    for (int i = 0; i < n; i++) begin
      Pipe1X = 10'd600; tick();
      Pipe1X = 10'd70;  tick();
    end
    BirdY = 10'd476;
    for (int i = 0; i < 31; i++) tick();
    BirdY = 10'd200;
  endtask

  task automatic test_high_score();
    total++; if (high_score !== 8'd0) begin bad++; $display("FAIL hs_reset got=%0d want=0", high_score); end
    play_and_crash(5);
    total++; if (game_over !== 1'b1 || high_score !== 8'd5) begin bad++; $display("FAIL hs_first got=%0b/%0d want=1/5", game_over, high_score); end
    keycode = 8'h00; tick();
    keycode = 8'h1A; tick(); tick();
    keycode = 8'h00;
    play_and_crash(3);
    total++; if (game_over !== 1'b1 || score !== 8'd3) begin bad++; $display("FAIL hs_second_game got=%0b/%0d want=1/3", game_over, score); end
    total++; if (high_score !== 8'd5) begin bad++; $display("FAIL hs_keep got=%0d want=5", high_score); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_scoring();
    test_floor_hit();
    test_restart();
    test_saturation();
    test_pipe_hit_and_reset();
`ifdef BIRD_HIGH_SCORE_EN
    test_high_score();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
